config_write_arbiter: RTL and testbench
=======================================

# config_write_arbiter

Round-robin arbiter that shares the single memory-mapped configuration write bus (`config_addr`/`config_data`) feeding the Controlpath and Datapath among several write sources. Example sources are an external loader, a debug port and thread-issued I/O writes. Each requester has a valid/ready handshake and a one-entry holding buffer. The block issues at most one registered configuration write per cycle. When no write is issued, it drives a parameterized unmapped address so that no Flow Control, Instruction Memory or Opcode Decoder location is modified.

## Interface
Parameters:
- `ADDR_WIDTH`, 10, config address width.
- `WORD_WIDTH`, 36, config data width.
- `REQUESTER_COUNT`, 4, number of write sources (≥2).
- `REQUESTER_WIDTH`, 2, clog2(`REQUESTER_COUNT`).
- `IDLE_ADDR`, 1023, unmapped address driven when no write is issued.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `hold` in 1: when high, no new grant is made.
- `req_valid` in `REQUESTER_COUNT`: per-requester write offered.
- `req_ready` out `REQUESTER_COUNT`: per-requester write accepted when high together with valid.
- `req_addr` in `REQUESTER_COUNT*ADDR_WIDTH`: packed; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_data` in `REQUESTER_COUNT*WORD_WIDTH`: packed, same slicing.
- `config_valid` out 1: registered; a write is on the bus this cycle.
- `config_addr` out `ADDR_WIDTH`: registered write address.
- `config_data` out `WORD_WIDTH`: registered write data.
- `grant_id` out `REQUESTER_WIDTH`: registered index of the requester that owns the current bus write.

## Operation
- Each requester i has one buffer entry: `full[i]`, `addr[i]`, `data[i]`.
- Arbitration is combinational, each cycle:
  - If `hold` is low and any `full[i]` is set, grant the first full buffer found searching upward and wrapping, starting at `last_grant+1` mod `REQUESTER_COUNT`.
  - At most one grant per cycle.
- `req_ready[i] = !full[i] | grant[i]`. A granted buffer can therefore be refilled on the same edge, giving back-to-back writes from a single requester.
- Clock edge actions:
  - Accept: when `req_valid[i] & req_ready[i]`, load the buffer and set `full[i]`.
  - Grant without refill: a granted buffer that is not refilled on the same edge clears `full[i]`.
  - Output on grant: the output register takes the granted entry; `config_valid=1`; `grant_id`=i; `last_grant`=i.
  - Output with no grant: `config_valid=0`, `config_addr=IDLE_ADDR`, `config_data=0`; `grant_id` and `last_grant` hold.
- Consumers decode writes by address range only. `IDLE_ADDR` must lie outside every mapped base range: `FC_BASE_ADDR_WRITE`, `IM_BASE_ADDR_WRITE`, `OD_BASE_ADDR_WRITE` and `DB_BASE_ADDR`.
- Reset values:
  - all `full`=0, so `req_ready` is all ones;
  - `last_grant`=`REQUESTER_COUNT-1`, so requester 0 has first priority;
  - `config_valid`=0, `config_addr`=`IDLE_ADDR`, `config_data`=0, `grant_id`=0.
- Reset mid-operation: buffered and in-flight writes are discarded. No write is issued until a fresh accept after `reset_n` deasserts.

## Timing
- Latency: a request accepted at edge k appears on `config_*` after edge k+1, provided it is uncontended and `hold` is low.
- Throughput:
  - one write per cycle total;
  - one write per cycle for a sole active requester;
  - under full contention, each requester gets 1 write per `REQUESTER_COUNT` cycles.
- Fairness: a full buffer waits at most `REQUESTER_COUNT-1` grants after `hold` is low.
- `hold` takes effect in the same cycle. The output goes idle at the next edge and stays idle while `hold` is high. Buffers keep their contents, and `req_ready[i]` is low for full buffers.
- Simultaneous events:
  - Accept and grant on the same buffer in the same cycle: new data loads and `full` stays set.
  - `req_valid` low while full: the entry persists; the request cannot be withdrawn.
- Requesters must hold `req_valid`, `req_addr` and `req_data` stable until accepted.

## Test plan
- Reset: with `reset_n` low, outputs are `config_valid=0`, `config_addr=1023`, `config_data=0`, `grant_id=0`, and `req_ready=4'b1111`. This also holds when `reset_n` is asserted asynchronously between edges.
- Single write and streaming:
  - Requester 1 offers addr 0x005, data 0x123 at edge 1. Required: `config_valid=1`, addr 0x005, data 0x123, `grant_id=1` after edge 2.
  - Four consecutive offers from requester 1 produce four consecutive bus writes with `req_ready[1]` high throughout.
- Contention: after reset, all four requesters offer continuously with distinct addresses. Required grant order on the bus: 0,1,2,3,0,1,…, with no idle cycle.
- Hold:
  - All buffers full; assert `hold` for 3 cycles. Required: `config_valid=0`, addr 1023, `req_ready=0`.
  - Release `hold` with `last_grant`=1. The next grants are 2,3,0,1.
- Fairness: requester 2 offers continuously and requester 0 offers one write. Requester 0 is granted within 2 cycles of acceptance; requester 2 loses at most one slot.
- Reset mid-operation: three buffers full and one write in the output register, then pulse `reset_n` low. Required: `config_valid=0` immediately, and no stale write ever appears after release.

Source files
------------

// File: rtl/config_write_arbiter.sv
// Round-robin arbiter sharing the registered configuration write bus among
// several write sources, each with a one-entry holding buffer.
module config_write_arbiter #(
  parameter int          ADDR_WIDTH      = 10,
  parameter int          WORD_WIDTH      = 36,
  parameter int          REQUESTER_COUNT = 4,
  parameter int          REQUESTER_WIDTH = 2,
  parameter int unsigned IDLE_ADDR       = 1023
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic                                  hold,
  input  logic [REQUESTER_COUNT-1:0]            req_valid,
  output logic [REQUESTER_COUNT-1:0]            req_ready,
  input  logic [REQUESTER_COUNT*ADDR_WIDTH-1:0] req_addr,
  input  logic [REQUESTER_COUNT*WORD_WIDTH-1:0] req_data,
  output logic                                  config_valid,
  output logic [ADDR_WIDTH-1:0]                 config_addr,
  output logic [WORD_WIDTH-1:0]                 config_data,
  output logic [REQUESTER_WIDTH-1:0]            grant_id
);

  localparam logic [ADDR_WIDTH-1:0]      IDLE_ADDR_W = ADDR_WIDTH'(IDLE_ADDR);
  localparam logic [REQUESTER_WIDTH-1:0] LAST_INIT   = REQUESTER_WIDTH'(REQUESTER_COUNT - 1);

  logic [REQUESTER_COUNT-1:0] full;
  logic [ADDR_WIDTH-1:0]      buf_addr [REQUESTER_COUNT];
  logic [WORD_WIDTH-1:0]      buf_data [REQUESTER_COUNT];
  logic [REQUESTER_WIDTH-1:0] last_grant;

  logic [REQUESTER_WIDTH-1:0] cand [REQUESTER_COUNT];
  logic [REQUESTER_COUNT-1:0] grant;
  logic [REQUESTER_WIDTH-1:0] grant_idx;
  logic                       grant_any;
  logic [REQUESTER_COUNT-1:0] accept;

  // Search order: last_grant+1, last_grant+2, ... wrapping back to last_grant.
  always_comb begin
    for (int k = 0; k < REQUESTER_COUNT; k++) begin
      cand[k] = REQUESTER_WIDTH'((int'(last_grant) + k + 1) % REQUESTER_COUNT);
    end
  end

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    if (!hold) begin
      for (int k = 0; k < REQUESTER_COUNT; k++) begin
        if (!grant_any && full[cand[k]]) begin
          grant_any       = 1'b1;
          grant_idx       = cand[k];
          grant[cand[k]]  = 1'b1;
        end
      end
    end
  end

  // Handshake: a write transfers on an edge where req_valid[i] & req_ready[i];
  // the requester keeps valid/addr/data stable until then. A buffer being
  // granted this cycle frees up on the same edge, so it can accept again.
  assign req_ready = ~full | grant;
  assign accept    = req_valid & req_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      full <= '0;
      for (int i = 0; i < REQUESTER_COUNT; i++) begin
        buf_addr[i] <= '0;
        buf_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < REQUESTER_COUNT; i++) begin
        if (accept[i]) begin
          full[i]     <= 1'b1;
          buf_addr[i] <= req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          buf_data[i] <= req_data[i*WORD_WIDTH +: WORD_WIDTH];
        end else if (grant[i]) begin
          full[i] <= 1'b0;
        end
      end
    end
  end

  // Idle cycles park the bus on an unmapped address so no consumer decodes a write.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      config_valid <= 1'b0;
      config_addr  <= IDLE_ADDR_W;
      config_data  <= '0;
      grant_id     <= '0;
      last_grant   <= LAST_INIT;
    end else if (grant_any) begin
      config_valid <= 1'b1;
      config_addr  <= buf_addr[grant_idx];
      config_data  <= buf_data[grant_idx];
      grant_id     <= grant_idx;
      last_grant   <= grant_idx;
    end else begin
      config_valid <= 1'b0;
      config_addr  <= IDLE_ADDR_W;
      config_data  <= '0;
    end
  end

endmodule

// File: tb/tb_config_write_arbiter.sv
// Bench for config_write_arbiter: directed scenarios plus randomized traffic
// checked against a buffer-level reference model and an expected-write queue.
module tb_config_write_arbiter;

  localparam int AW   = 10;
  localparam int WW   = 36;
  localparam int N    = 4;
  localparam int RW   = 2;
  localparam int IDLE = 1023;
  localparam int EW   = RW + AW + WW;

  // ---------------- clock / reset ----------------
  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic hold    = 1'b0;
  always #5 clock = ~clock;

  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr  = '0;
  logic [N*WW-1:0] req_data  = '0;
  logic            config_valid;
  logic [AW-1:0]   config_addr;
  logic [WW-1:0]   config_data;
  logic [RW-1:0]   grant_id;

  config_write_arbiter #(
    .ADDR_WIDTH(AW), .WORD_WIDTH(WW), .REQUESTER_COUNT(N),
    .REQUESTER_WIDTH(RW), .IDLE_ADDR(IDLE)
  ) dut (
    .clock(clock), .reset_n(reset_n), .hold(hold),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .config_valid(config_valid), .config_addr(config_addr),
    .config_data(config_data), .grant_id(grant_id)
  );

  // ---------------- requester offers ----------------
  logic          off_v [N];
  logic [AW-1:0] off_a [N];
  logic [WW-1:0] off_d [N];
  logic [N-1:0]  last_acc;
  logic [N-1:0]  rdy_seen;

  // ---------------- reference model + scoreboard ----------------
  bit            m_full [N];
  logic [AW-1:0] m_addr [N];
  logic [WW-1:0] m_data [N];
  int            m_last;
  logic [RW-1:0] m_gid;
  logic [EW-1:0] exp_q [$];

  int n_cmp = 0;
  int n_err = 0;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) m_full[i] = 0;
    m_last = N - 1;
    m_gid  = '0;
    exp_q.delete();
  endfunction

  // Round-robin pick: first pending entry after the previous winner.
  function automatic int model_pick();
    if (hold) return -1;
    for (int k = 1; k <= N; k++) begin
      if (m_full[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  // ---------------- driver ----------------
  task automatic step();
    int g;
    logic [N-1:0] exp_rdy;
    logic [EW-1:0] exp_w;
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = off_v[i];
      req_addr[i*AW +: AW]  = off_a[i];
      req_data[i*WW +: WW]  = off_d[i];
    end
    #1;
    g = model_pick();
    for (int i = 0; i < N; i++) exp_rdy[i] = !m_full[i] || (g == i);
    rdy_seen = req_ready;
    n_cmp++;
    if (req_ready !== exp_rdy) begin
      n_err++;
      $display("FAIL ready t=%0t got %b exp %b", $time, req_ready, exp_rdy);
    end
    @(posedge clock);
    last_acc = '0;
    if (g >= 0) begin
      exp_q.push_back({RW'(g), m_addr[g], m_data[g]});
      m_full[g] = 0;
      m_last    = g;
      m_gid     = RW'(g);
    end
    for (int i = 0; i < N; i++) begin
      if (off_v[i] && exp_rdy[i]) begin
        m_full[i]   = 1;
        m_addr[i]   = off_a[i];
        m_data[i]   = off_d[i];
        last_acc[i] = 1'b1;
      end
    end
    #1;
    n_cmp++;
    if (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      if (config_valid !== 1'b1 || {grant_id, config_addr, config_data} !== exp_w) begin
        n_err++;
        $display("FAIL write t=%0t got v=%b %h exp v=1 %h", $time, config_valid,
                 {grant_id, config_addr, config_data}, exp_w);
      end
    end else if (config_valid !== 1'b0 || config_addr !== AW'(IDLE) ||
                 config_data !== '0 || grant_id !== m_gid) begin
      n_err++;
      $display("FAIL idle t=%0t got v=%b a=%h d=%h id=%0d exp v=0 a=%h d=0 id=%0d",
               $time, config_valid, config_addr, config_data, grant_id, AW'(IDLE), m_gid);
    end
  endtask

  task automatic retire();
    for (int i = 0; i < N; i++) if (last_acc[i]) off_v[i] = 1'b0;
  endtask

  task automatic clear_offers();
    for (int i = 0; i < N; i++) begin
      off_v[i] = 1'b0;
      off_a[i] = '0;
      off_d[i] = '0;
    end
  endtask

  task automatic do_reset();
    hold = 1'b0;
    clear_offers();
    req_valid = '0;
    reset_n   = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    step();
    off_v[2] = 1'b1; off_a[2] = 10'h0aa; off_d[2] = 36'h5;
    step();
    retire();
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (config_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", config_valid); end
    n_cmp++; if (config_addr !== AW'(IDLE)) begin n_err++; $display("FAIL rst_addr got %h exp %h", config_addr, AW'(IDLE)); end
    n_cmp++; if (config_data !== '0) begin n_err++; $display("FAIL rst_data got %h exp 0", config_data); end
    n_cmp++; if (grant_id !== '0) begin n_err++; $display("FAIL rst_gid got %0d exp 0", grant_id); end
    n_cmp++; if (req_ready !== 4'b1111) begin n_err++; $display("FAIL rst_ready got %b exp 1111", req_ready); end
    @(posedge clock); #1;
    n_cmp++;
    if (config_valid !== 1'b0 || req_ready !== 4'b1111) begin
      n_err++;
      $display("FAIL rst_hold got v=%b r=%b exp v=0 r=1111", config_valid, req_ready);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    off_v[1] = 1'b1; off_a[1] = 10'h005; off_d[1] = 36'h123;
    step();
    retire();
    step();
    n_cmp++;
    if (config_valid !== 1'b1 || config_addr !== 10'h005 || config_data !== 36'h123 || grant_id !== 2'd1) begin
      n_err++;
      $display("FAIL single got v=%b a=%h d=%h id=%0d exp v=1 a=005 d=123 id=1",
               config_valid, config_addr, config_data, grant_id);
    end
  endtask

  task automatic test_streaming();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        off_v[1] = 1'b1; off_a[1] = AW'(10'h040 + k); off_d[1] = {4'h0, $urandom()};
      end else begin
        off_v[1] = 1'b0;
      end
      step();
      if (k < 4) begin
        n_cmp++;
        if (rdy_seen[1] !== 1'b1) begin n_err++; $display("FAIL stream_ready k=%0d got 0 exp 1", k); end
      end
      if (k >= 1) begin
        n_cmp++;
        if (config_valid !== 1'b1 || config_addr !== AW'(10'h040 + k - 1)) begin
          n_err++;
          $display("FAIL stream_write k=%0d got v=%b a=%h exp v=1 a=%h", k, config_valid,
                   config_addr, AW'(10'h040 + k - 1));
        end
      end
    end
  endtask

  task automatic test_contention();
    do_reset();
    for (int i = 0; i < N; i++) begin
      off_v[i] = 1'b1; off_a[i] = AW'(10'h100 + i * 16); off_d[i] = {4'h0, $urandom()};
    end
    for (int s = 0; s < 12; s++) begin
      step();
      for (int i = 0; i < N; i++) if (last_acc[i]) begin
        off_a[i] = off_a[i] + 1'b1; off_d[i] = {4'h0, $urandom()};
      end
      if (s >= 1) begin
        n_cmp++;
        if (config_valid !== 1'b1 || grant_id !== RW'((s - 1) % N)) begin
          n_err++;
          $display("FAIL contention s=%0d got v=%b id=%0d exp v=1 id=%0d", s, config_valid,
                   grant_id, (s - 1) % N);
        end
      end
    end
  endtask

  task automatic test_hold();
    int order [4] = '{2, 3, 0, 1};
    do_reset();
    for (int i = 0; i < N; i++) begin
      off_v[i] = 1'b1; off_a[i] = AW'(10'h200 + i * 16); off_d[i] = {4'h0, $urandom()};
    end
    for (int s = 0; s < 3; s++) begin
      step();
      for (int i = 0; i < N; i++) if (last_acc[i]) begin
        off_a[i] = off_a[i] + 1'b1; off_d[i] = {4'h0, $urandom()};
      end
    end
    hold = 1'b1;
    for (int s = 0; s < 3; s++) begin
      step();
      n_cmp++;
      if (config_valid !== 1'b0 || config_addr !== AW'(IDLE) || rdy_seen !== 4'b0000) begin
        n_err++;
        $display("FAIL hold s=%0d got v=%b a=%h r=%b exp v=0 a=%h r=0000", s, config_valid,
                 config_addr, rdy_seen, AW'(IDLE));
      end
    end
    hold = 1'b0;
    for (int s = 0; s < 4; s++) begin
      step();
      for (int i = 0; i < N; i++) if (last_acc[i]) begin
        off_a[i] = off_a[i] + 1'b1; off_d[i] = {4'h0, $urandom()};
      end
      n_cmp++;
      if (config_valid !== 1'b1 || grant_id !== RW'(order[s])) begin
        n_err++;
        $display("FAIL hold_release s=%0d got v=%b id=%0d exp v=1 id=%0d", s, config_valid,
                 grant_id, order[s]);
      end
    end
    clear_offers();
    repeat (4) step();
  endtask

  task automatic test_fairness();
    int wait_cyc;
    int lost;
    bit seen0;
    do_reset();
    off_v[2] = 1'b1; off_a[2] = 10'h300; off_d[2] = 36'h1;
    repeat (3) begin
      step();
      if (last_acc[2]) begin off_a[2] = off_a[2] + 1'b1; off_d[2] = {4'h0, $urandom()}; end
    end
    off_v[0] = 1'b1; off_a[0] = 10'h010; off_d[0] = 36'hf00d;
    for (int s = 0; s < 4 && off_v[0]; s++) begin
      step();
      retire();
      if (last_acc[2]) begin off_v[2] = 1'b1; off_a[2] = off_a[2] + 1'b1; end
    end
    off_v[2] = 1'b1;
    wait_cyc = 0; lost = 0; seen0 = 0;
    for (int s = 0; s < 4; s++) begin
      step();
      if (last_acc[2]) begin off_a[2] = off_a[2] + 1'b1; off_d[2] = {4'h0, $urandom()}; end
      if (!seen0) wait_cyc++;
      if (config_valid === 1'b1 && grant_id === 2'd0) seen0 = 1;
      if (!(config_valid === 1'b1 && grant_id === 2'd2)) lost++;
    end
    n_cmp++;
    if (!seen0 || wait_cyc > 2) begin
      n_err++;
      $display("FAIL fair_wait got seen=%0d cycles=%0d exp seen=1 cycles<=2", seen0, wait_cyc);
    end
    n_cmp++;
    if (lost > 1) begin n_err++; $display("FAIL fair_lost got %0d exp <=1", lost); end
    clear_offers();
    repeat (3) step();
  endtask

  task automatic test_random();
    do_reset();
    for (int s = 0; s < 400; s++) begin
      hold = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < N; i++) begin
        if (!off_v[i] && $urandom_range(0, 2) != 0) begin
          off_v[i] = 1'b1;
          off_a[i] = AW'($urandom_range(0, 1022));
          off_d[i] = {4'($urandom_range(0, 15)), $urandom()};
        end
      end
      step();
      retire();
    end
    hold = 1'b0;
    clear_offers();
    repeat (6) step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < N; i++) begin
      off_v[i] = 1'b1; off_a[i] = AW'(10'h050 + i); off_d[i] = {4'h0, $urandom()};
    end
    step();
    retire();
    step();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (config_valid !== 1'b0 || config_addr !== AW'(IDLE) || req_ready !== 4'b1111) begin
      n_err++;
      $display("FAIL mid_reset got v=%b a=%h r=%b exp v=0 a=%h r=1111", config_valid,
               config_addr, req_ready, AW'(IDLE));
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int s = 0; s < 6; s++) begin
      step();
      n_cmp++;
      if (config_valid !== 1'b0) begin n_err++; $display("FAIL stale s=%0d got v=1 exp v=0", s); end
    end
    off_v[3] = 1'b1; off_a[3] = 10'h077; off_d[3] = 36'hbeef;
    step();
    retire();
    step();
    n_cmp++;
    if (config_valid !== 1'b1 || config_addr !== 10'h077 || grant_id !== 2'd3) begin
      n_err++;
      $display("FAIL post_reset got v=%b a=%h id=%0d exp v=1 a=077 id=3", config_valid,
               config_addr, grant_id);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    clear_offers();
    model_reset();
    test_reset();
    test_single();
    test_streaming();
    test_contention();
    test_hold();
    test_fairness();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout sim time exceeded");
    $fatal(1);
  end

endmodule
